// File: rtl/pe_noc_interface_if.sv
// Host and router signal bundle for the PE-side NoC endpoint.
// slave  : the endpoint itself (pe_noc_interface).
// master : the environment that drives the endpoint, i.e. host plus router PE port.
// Signals:
//   TX host side : i_tx_valid, o_tx_ready, i_tx_dest_x, i_tx_dest_y, i_tx_data
//   to router    : o_noc_valid, i_noc_ready, o_noc_data
//   from router  : i_noc_valid, i_noc_data (no backpressure)
//   RX host side : o_rx_valid, i_rx_ready, o_rx_data
//   status       : o_drop_cnt (saturating RX overflow count)
interface pe_noc_interface_if #(
    parameter int unsigned X_SIZE = 4,
    parameter int unsigned Y_SIZE = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned PKT_W = X_SIZE + Y_SIZE + DATA_W;

    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [X_SIZE-1:0] i_tx_dest_x;
    logic [Y_SIZE-1:0] i_tx_dest_y;
    logic [DATA_W-1:0] i_tx_data;

    logic              o_noc_valid;
    logic              i_noc_ready;
    logic [PKT_W-1:0]  o_noc_data;

    logic              i_noc_valid;
    logic [PKT_W-1:0]  i_noc_data;

    logic              o_rx_valid;
    logic              i_rx_ready;
    logic [DATA_W-1:0] o_rx_data;

    logic [7:0]        o_drop_cnt;

    modport slave (
        input  i_tx_valid, i_tx_dest_x, i_tx_dest_y, i_tx_data,
        input  i_noc_ready, i_noc_valid, i_noc_data, i_rx_ready,
        output o_tx_ready, o_noc_valid, o_noc_data, o_rx_valid, o_rx_data, o_drop_cnt
    );

    modport master (
        output i_tx_valid, i_tx_dest_x, i_tx_dest_y, i_tx_data,
        output i_noc_ready, i_noc_valid, i_noc_data, i_rx_ready,
        input  o_tx_ready, o_noc_valid, o_noc_data, o_rx_valid, o_rx_data, o_drop_cnt
    );
endinterface

// File: rtl/pe_noc_interface.sv
// PE-side endpoint of the mesh router PE port.
// TX: host packets {payload, y, x} are buffered in a FWFT FIFO and injected into the
//     router under valid/ready; packets addressed to this node loop back into RX.
// RX: every router ejection is captured into a FIFO for the host; overflow is dropped
//     and counted (saturating at 255). Router arrivals take priority over loopback.
// Ports: clk, rstn (async active-low), bus (pe_noc_interface_if.slave, see interface).
module pe_noc_interface #(
    parameter int unsigned X_COORD  = 0,
    parameter int unsigned Y_COORD  = 0,
    parameter int unsigned X_SIZE   = 4,
    parameter int unsigned Y_SIZE   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    pe_noc_interface_if.slave     bus
);
    localparam int unsigned ADDR_W = X_SIZE + Y_SIZE;
    localparam int unsigned PKT_W  = ADDR_W + DATA_W;
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW  = $clog2(RX_DEPTH);

    localparam logic [X_SIZE-1:0] OWN_X = X_SIZE'(X_COORD);
    localparam logic [Y_SIZE-1:0] OWN_Y = Y_SIZE'(Y_COORD);

    // ---------------- TX FIFO ----------------
    logic [PKT_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]   tx_wr_ptr;
    logic [TX_AW:0]   tx_rd_ptr;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_push;
    logic             tx_pop;
    logic [PKT_W-1:0] tx_head;
    logic             head_local;
    logic             noc_valid_c;
    logic             noc_fire;
    logic             lb_fire;

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]    rx_wr_ptr;
    logic [RX_AW:0]    rx_rd_ptr;
    logic              rx_empty;
    logic              rx_full;
    logic              rx_pop;
    logic              rx_room;
    logic              rx_push;
    logic              rx_drop;
    logic [DATA_W-1:0] rx_wdata;
    logic [7:0]        drop_cnt;

    // Only the payload of a router packet is kept; its address bits are not needed.
    logic unused_noc_addr;
    assign unused_noc_addr = ^bus.i_noc_data[ADDR_W-1:0];

    // FIFO status from extra-MSB pointers
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);

    assign tx_head    = tx_mem[tx_rd_ptr[TX_AW-1:0]];
    assign head_local = (tx_head[X_SIZE-1:0] == OWN_X) &&
                        (tx_head[ADDR_W-1:X_SIZE] == OWN_Y);

    // TX injection and loopback decisions
    assign tx_push     = bus.i_tx_valid && !tx_full;
    assign noc_valid_c = !tx_empty && !head_local;
    assign noc_fire    = noc_valid_c && bus.i_noc_ready;
    assign rx_pop      = !rx_empty && bus.i_rx_ready;
    // A full RX FIFO still has room when its head leaves on the same edge.
    assign rx_room     = !rx_full || rx_pop;
    // Loopback only uses the RX write port in cycles without a router arrival.
    assign lb_fire     = !tx_empty && head_local && !bus.i_noc_valid && rx_room;
    assign tx_pop      = noc_fire || lb_fire;

    assign rx_drop  = bus.i_noc_valid && !rx_room;
    assign rx_push  = (bus.i_noc_valid && rx_room) || lb_fire;
    assign rx_wdata = bus.i_noc_valid ? bus.i_noc_data[PKT_W-1:ADDR_W]
                                      : tx_head[PKT_W-1:ADDR_W];

    // TX storage (not reset: contents are only observed behind the pointers)
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {bus.i_tx_data, bus.i_tx_dest_y, bus.i_tx_dest_x};
        end
    end

    // RX storage
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_wdata;
        end
    end

    // Pointers and drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            drop_cnt  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
            if (rx_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Outputs are decoded from registered FIFO state only; data is zeroed when not valid.
    assign bus.o_tx_ready  = !tx_full;
    assign bus.o_noc_valid = noc_valid_c;
    assign bus.o_noc_data  = noc_valid_c ? tx_head : '0;
    assign bus.o_rx_valid  = !rx_empty;
    assign bus.o_rx_data   = rx_empty ? '0 : rx_mem[rx_rd_ptr[RX_AW-1:0]];
    assign bus.o_drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_pe_noc_interface.sv
// Directed bench for pe_noc_interface: a per-cycle vector table for the basic paths,
// then hand sequences for backpressure, loopback priority, overflow and async reset.
// The node sits at (1,2) so swapped x/y handling is visible.
module tb_pe_noc_interface;
    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    pe_noc_interface_if #(.X_SIZE(4), .Y_SIZE(4), .DATA_W(32)) bus ();

    pe_noc_interface #(
        .X_COORD(1), .Y_COORD(2), .X_SIZE(4), .Y_SIZE(4),
        .DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic        tx_valid;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [31:0] tx_data;
        logic        noc_ready;
        logic        nv_in;
        logic [39:0] nd_in;
        logic        rx_ready;
        logic        e_tx_ready;
        logic        e_noc_valid;
        logic [39:0] e_noc_data;
        logic        e_rx_valid;
        logic [31:0] e_rx_data;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_q [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_tx_valid  = 1'b0;
        bus.i_tx_dest_x = 4'h0;
        bus.i_tx_dest_y = 4'h0;
        bus.i_tx_data   = 32'h0;
        bus.i_noc_ready = 1'b0;
        bus.i_noc_valid = 1'b0;
        bus.i_noc_data  = 40'h0;
        bus.i_rx_ready  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        step();
        step();

        // Reset state
        chk("reset_tx_ready",  64'(bus.o_tx_ready),  64'd1);
        chk("reset_noc_valid", 64'(bus.o_noc_valid), 64'd0);
        chk("reset_noc_data",  64'(bus.o_noc_data),  64'd0);
        chk("reset_rx_valid",  64'(bus.o_rx_valid),  64'd0);
        chk("reset_drop_cnt",  64'(bus.o_drop_cnt),  64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Per-cycle table: inputs before an edge, expected outputs just after it
        vecs[0] = '{1'b1, 4'd2, 4'd1, 32'hA5A5A5A5, 1'b1, 1'b0, 40'h0, 1'b0,
                    1'b1, 1'b1, 40'hA5A5A5A5_12, 1'b0, 32'h0, 8'd0};
        vecs[1] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b0, 40'h0, 1'b0,
                    1'b1, 1'b0, 40'h0, 1'b0, 32'h0, 8'd0};
        vecs[2] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1, 40'h11110001_21, 1'b0,
                    1'b1, 1'b0, 40'h0, 1'b1, 32'h11110001, 8'd0};
        vecs[3] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b0, 40'h0, 1'b1,
                    1'b1, 1'b0, 40'h0, 1'b0, 32'h0, 8'd0};
        vecs[4] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1, 40'hDEADBEEF_33, 1'b0,
                    1'b1, 1'b0, 40'h0, 1'b1, 32'hDEADBEEF, 8'd0};
        vecs[5] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b1, 40'hCAFE0001_44, 1'b1,
                    1'b1, 1'b0, 40'h0, 1'b1, 32'hCAFE0001, 8'd0};
        vecs[6] = '{1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b0, 40'h0, 1'b1,
                    1'b1, 1'b0, 40'h0, 1'b0, 32'h0, 8'd0};

        for (int i = 0; i < 7; i++) begin
            bus.i_tx_valid  = vecs[i].tx_valid;
            bus.i_tx_dest_x = vecs[i].dx;
            bus.i_tx_dest_y = vecs[i].dy;
            bus.i_tx_data   = vecs[i].tx_data;
            bus.i_noc_ready = vecs[i].noc_ready;
            bus.i_noc_valid = vecs[i].nv_in;
            bus.i_noc_data  = vecs[i].nd_in;
            bus.i_rx_ready  = vecs[i].rx_ready;
            step();
            chk($sformatf("vec%0d_tx_ready", i),  64'(bus.o_tx_ready),  64'(vecs[i].e_tx_ready));
            chk($sformatf("vec%0d_noc_valid", i), 64'(bus.o_noc_valid), 64'(vecs[i].e_noc_valid));
            if (vecs[i].e_noc_valid)
                chk($sformatf("vec%0d_noc_data", i), 64'(bus.o_noc_data), 64'(vecs[i].e_noc_data));
            chk($sformatf("vec%0d_rx_valid", i),  64'(bus.o_rx_valid),  64'(vecs[i].e_rx_valid));
            if (vecs[i].e_rx_valid)
                chk($sformatf("vec%0d_rx_data", i), 64'(bus.o_rx_data), 64'(vecs[i].e_rx_data));
            chk($sformatf("vec%0d_drop", i),      64'(bus.o_drop_cnt),  64'(vecs[i].e_drop));
        end
        idle_inputs();

        // Backpressure: 5 push attempts with the router stalled, only 4 fit
        bus.i_noc_ready = 1'b0;
        bus.i_tx_valid  = 1'b1;
        bus.i_tx_dest_x = 4'd2;
        bus.i_tx_dest_y = 4'd1;
        for (int k = 0; k < 5; k++) begin
            bus.i_tx_data = 32'hD0000000 + 32'(k);
            step();
            chk($sformatf("bp_tx_ready%0d", k), 64'(bus.o_tx_ready), (k < 3) ? 64'd1 : 64'd0);
            chk($sformatf("bp_noc_valid%0d", k), 64'(bus.o_noc_valid), 64'd1);
            chk($sformatf("bp_noc_data%0d", k), 64'(bus.o_noc_data), 64'h00_D0000000_12);
        end
        bus.i_tx_valid  = 1'b0;
        bus.i_noc_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_noc_valid%0d", k), 64'(bus.o_noc_valid), 64'd1);
            chk($sformatf("drain_noc_data%0d", k), 64'(bus.o_noc_data),
                64'({32'hD0000000 + 32'(k), 4'h1, 4'h2}));
            step();
        end
        chk("drain_noc_valid_end", 64'(bus.o_noc_valid), 64'd0);
        chk("drain_tx_ready_end",  64'(bus.o_tx_ready),  64'd1);
        idle_inputs();

        // Loopback to own node (1,2)
        bus.i_tx_valid  = 1'b1;
        bus.i_tx_dest_x = 4'd1;
        bus.i_tx_dest_y = 4'd2;
        bus.i_tx_data   = 32'h11;
        step();
        bus.i_tx_valid = 1'b0;
        chk("lb_noc_valid_a", 64'(bus.o_noc_valid), 64'd0);
        chk("lb_rx_valid_a",  64'(bus.o_rx_valid),  64'd0);
        step();
        chk("lb_noc_valid_b", 64'(bus.o_noc_valid), 64'd0);
        chk("lb_rx_valid_b",  64'(bus.o_rx_valid),  64'd1);
        chk("lb_rx_data",     64'(bus.o_rx_data),   64'h11);
        bus.i_rx_ready = 1'b1;
        step();
        bus.i_rx_ready = 1'b0;
        chk("lb_rx_popped", 64'(bus.o_rx_valid), 64'd0);

        // Loopback pending while the router ejects for 3 cycles: router packets go first
        bus.i_tx_valid  = 1'b1;
        bus.i_tx_data   = 32'h22;
        bus.i_noc_valid = 1'b1;
        bus.i_noc_data  = {32'hB0000001, 8'h00};
        step();
        bus.i_tx_valid = 1'b0;
        bus.i_noc_data = {32'hB0000002, 8'h00};
        step();
        bus.i_noc_data = {32'hB0000003, 8'h00};
        step();
        bus.i_noc_valid = 1'b0;
        chk("prio_noc_valid", 64'(bus.o_noc_valid), 64'd0);
        step();
        exp_q[0] = 32'hB0000001;
        exp_q[1] = 32'hB0000002;
        exp_q[2] = 32'hB0000003;
        exp_q[3] = 32'h22;
        bus.i_rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("prio_rx_valid%0d", k), 64'(bus.o_rx_valid), 64'd1);
            chk($sformatf("prio_rx_data%0d", k),  64'(bus.o_rx_data),  64'(exp_q[k]));
            step();
        end
        chk("prio_rx_empty", 64'(bus.o_rx_valid), 64'd0);
        idle_inputs();

        // Overflow: six arrivals into a 4-deep RX with no host pops
        bus.i_noc_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.i_noc_data = {32'hE0000000 + 32'(k), 8'h55};
            step();
            chk($sformatf("ovf_drop%0d", k), 64'(bus.o_drop_cnt), (k < 4) ? 64'd0 : 64'(k - 3));
        end
        chk("ovf_head", 64'(bus.o_rx_data), 64'hE0000000);
        bus.i_noc_data = {32'hE0000006, 8'h55};
        bus.i_rx_ready = 1'b1;
        step();
        bus.i_rx_ready = 1'b0;
        chk("ovf_popaccept_drop", 64'(bus.o_drop_cnt), 64'd2);
        chk("ovf_popaccept_head", 64'(bus.o_rx_data),  64'hE0000001);
        for (int k = 0; k < 255; k++) begin
            bus.i_noc_data = {32'hF0000000 + 32'(k), 8'h00};
            step();
        end
        bus.i_noc_valid = 1'b0;
        chk("ovf_saturate", 64'(bus.o_drop_cnt), 64'd255);

        // Loopback stalls against a full RX, then enters on a pop edge
        bus.i_tx_valid  = 1'b1;
        bus.i_tx_dest_x = 4'd1;
        bus.i_tx_dest_y = 4'd2;
        bus.i_tx_data   = 32'h33;
        step();
        bus.i_tx_valid = 1'b0;
        step();
        step();
        chk("stall_rx_head",   64'(bus.o_rx_data),   64'hE0000001);
        chk("stall_noc_valid", 64'(bus.o_noc_valid), 64'd0);
        chk("stall_tx_ready",  64'(bus.o_tx_ready),  64'd1);
        exp_q[0] = 32'hE0000001;
        exp_q[1] = 32'hE0000002;
        exp_q[2] = 32'hE0000003;
        exp_q[3] = 32'hE0000006;
        exp_q[4] = 32'h33;
        bus.i_rx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_rx_valid%0d", k), 64'(bus.o_rx_valid), 64'd1);
            chk($sformatf("stall_rx_data%0d", k),  64'(bus.o_rx_data),  64'(exp_q[k]));
            step();
        end
        chk("stall_rx_empty", 64'(bus.o_rx_valid), 64'd0);
        chk("stall_drop_kept", 64'(bus.o_drop_cnt), 64'd255);
        idle_inputs();

        // Async reset mid-stream with both FIFOs partly filled
        bus.i_tx_valid  = 1'b1;
        bus.i_tx_dest_x = 4'd3;
        bus.i_tx_dest_y = 4'd3;
        bus.i_noc_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.i_tx_data  = 32'hA0000000 + 32'(k);
            bus.i_noc_data = {32'hC0000000 + 32'(k), 8'h12};
            step();
        end
        idle_inputs();
        chk("pre_rst_noc_valid", 64'(bus.o_noc_valid), 64'd1);
        chk("pre_rst_rx_valid",  64'(bus.o_rx_valid),  64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_noc_valid", 64'(bus.o_noc_valid), 64'd0);
        chk("async_rst_noc_data",  64'(bus.o_noc_data),  64'd0);
        chk("async_rst_rx_valid",  64'(bus.o_rx_valid),  64'd0);
        chk("async_rst_drop",      64'(bus.o_drop_cnt),  64'd0);
        chk("async_rst_tx_ready",  64'(bus.o_tx_ready),  64'd1);
        @(negedge clk);
        rstn = 1'b1;
        bus.i_noc_ready = 1'b1;
        step();
        step();
        chk("post_rst_noc_valid", 64'(bus.o_noc_valid), 64'd0);
        chk("post_rst_rx_valid",  64'(bus.o_rx_valid),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
